// File: rtl/mode_select_debounce.sv
// Push-button debouncer: the debounced level flips only after DEB_CYCLES
// consecutive raw samples disagree with it. rise_pulse is high for the one cycle after a 0->1 flip.
module mode_select_debounce #(
  parameter int DEB_CYCLES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out,
  output logic rise_pulse
);

  localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       state_q, state_d;
  logic       rise_q, rise_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    // Any agreeing sample restarts the count, so short glitches are dropped.
    if (btn_in != state_q) begin
      if (cnt_q == LAST) begin
        state_d = ~state_q;
        rise_d  = ~state_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
    end
  end

  assign btn_out    = state_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/mode_select.sv
// Mode/limit control for the advanced counter: debounced toggles for carry and
// max-limit modes, plus a level-loaded 24-bit max limit register.
module mode_select #(
  parameter int DEB_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] cnt_in,
  input  logic        carry_set,
  input  logic        max_set,
  input  logic        refresh_limits,
  output logic [23:0] max_out,
  output logic        max_en,
  output logic        carry_en
);

  localparam int CNT_W   = 24;
  localparam int NUM_BTN = 2;
  localparam int B_CARRY = 0;
  localparam int B_MAX   = 1;

  logic [NUM_BTN-1:0] btn_raw, btn_deb, btn_rise;
  logic [NUM_BTN-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]   max_out_q, max_out_d;

  assign btn_raw = {max_set, carry_set};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    mode_select_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (btn_raw[b]),
      .btn_out   (btn_deb[b]),
      .rise_pulse(btn_rise[b])
    );
  end

  always_comb begin
    // Pulse is only ever raised while the debounced level is high; gate anyway.
    mode_d    = mode_q ^ (btn_rise & btn_deb);
    max_out_d = refresh_limits ? cnt_in : max_out_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q    <= '0;
      max_out_q <= '0;
    end else begin
      mode_q    <= mode_d;
      max_out_q <= max_out_d;
    end
  end

  assign max_out  = max_out_q;
  assign carry_en = mode_q[B_CARRY];
  // A zero limit never enables limiting, whatever the mode register says.
  assign max_en   = mode_q[B_MAX] & (max_out_q != '0);

endmodule

// File: tb/tb_mode_select.sv
// Directed bench for mode_select: behavioural model checked every cycle plus
// hand-computed literal expectations at key points of each scenario.
module tb_mode_select;

  localparam int DEB = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] cnt_in;
  logic        carry_set, max_set, refresh_limits;
  logic [23:0] max_out;
  logic        max_en, carry_en;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  mode_select #(.DEB_CYCLES(DEB)) dut (
    .clk           (clk),
    .reset         (reset),
    .cnt_in        (cnt_in),
    .carry_set     (carry_set),
    .max_set       (max_set),
    .refresh_limits(refresh_limits),
    .max_out       (max_out),
    .max_en        (max_en),
    .carry_en      (carry_en)
  );

  always #5 clk = ~clk;

  // Model: each button tracks how long the raw input has disagreed with its
  // debounced level; a completed press schedules a mode flip for the next edge.
  int          streak [2];
  bit          deb    [2];
  bit          pend   [2];
  bit          mode   [2];
  logic [23:0] m_max;

  always @(posedge clk) begin
    bit raw [2];
    raw[0] = carry_set;
    raw[1] = max_set;
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        streak[b] = 0; deb[b] = 0; pend[b] = 0; mode[b] = 0;
      end
      m_max = 24'h0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (pend[b]) mode[b] = !mode[b];
        pend[b] = 0;
        if (raw[b] == deb[b]) streak[b] = 0;
        else begin
          streak[b]++;
          if (streak[b] >= DEB) begin
            deb[b]    = !deb[b];
            streak[b] = 0;
            pend[b]   = deb[b];
          end
        end
      end
      if (refresh_limits) m_max = cnt_in;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (max_out !== m_max || carry_en !== mode[0] ||
          max_en !== (mode[1] && m_max != 24'h0)) begin
        failures++;
        $display("FAIL model t=%0t got max_out=%h max_en=%b carry_en=%b want %h %b %b",
                 $time, max_out, max_en, carry_en, m_max,
                 (mode[1] && m_max != 24'h0), mode[0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic press(input bit is_max, input int n);
    if (is_max) max_set = 1'b1; else carry_set = 1'b1;
    cyc(n);
    if (is_max) max_set = 1'b0; else carry_set = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cnt_in = '0; carry_set = 0; max_set = 0; refresh_limits = 0;
    cyc(3);
    check_en = 1'b1;
    chk("rst_max_out", max_out, 24'h0);
    chk("rst_max_en", {23'h0, max_en}, 24'h0);
    chk("rst_carry_en", {23'h0, carry_en}, 24'h0);
    reset = 1'b1;
    cyc(2);

    // Carry press: flips exactly DEB+1 edges after the press starts.
    carry_set = 1'b1;
    cyc(DEB);
    chk("carry_before_deb", {23'h0, carry_en}, 24'h0);
    cyc(1);
    chk("carry_on_deb_plus1", {23'h0, carry_en}, 24'h1);
    cyc(3);
    carry_set = 1'b0;
    cyc(10);
    chk("carry_after_release", {23'h0, carry_en}, 24'h1);
    press(0, 10); cyc(10);
    chk("carry_second_press", {23'h0, carry_en}, 24'h0);
    press(0, 3); cyc(10);
    chk("carry_glitch", {23'h0, carry_en}, 24'h0);

    // Max mode with a zero limit stays disabled until a limit is loaded.
    press(1, 10); cyc(10);
    chk("max_en_zero_limit", {23'h0, max_en}, 24'h0);
    cnt_in = 24'h123456; refresh_limits = 1'b1;
    cyc(5);
    refresh_limits = 1'b0; cnt_in = 24'h0;
    cyc(2);
    chk("max_out_loaded", max_out, 24'h123456);
    chk("max_en_loaded", {23'h0, max_en}, 24'h1);

    // Overlapping presses one cycle apart: each mode toggles once.
    carry_set = 1'b1; cyc(1);
    max_set = 1'b1; cyc(9);
    carry_set = 1'b0; cyc(1);
    max_set = 1'b0; cyc(10);
    chk("both_carry", {23'h0, carry_en}, 24'h1);
    chk("both_max_en", {23'h0, max_en}, 24'h0);

    // Refresh tracking with carry held throughout.
    carry_set = 1'b1; refresh_limits = 1'b1; cnt_in = 24'h204302;
    cyc(5);
    cnt_in = 24'h020002;
    cyc(15);
    refresh_limits = 1'b0; carry_set = 1'b0; cnt_in = 24'hABCDEF;
    cyc(10);
    chk("refresh_last_value", max_out, 24'h020002);
    chk("held_carry_once", {23'h0, carry_en}, 24'h0);

    // Reset mid-press with a loaded limit and both modes on.
    cnt_in = 24'h004300; refresh_limits = 1'b1; cyc(1);
    refresh_limits = 1'b0;
    press(1, 10); press(0, 10); cyc(10);
    chk("pre_rst_max_en", {23'h0, max_en}, 24'h1);
    chk("pre_rst_carry", {23'h0, carry_en}, 24'h1);
    carry_set = 1'b1; cyc(3);
    reset = 1'b0; cyc(2);
    reset = 1'b1;
    chk("midrst_max_out", max_out, 24'h0);
    chk("midrst_max_en", {23'h0, max_en}, 24'h0);
    chk("midrst_carry", {23'h0, carry_en}, 24'h0);
    cyc(DEB);
    chk("post_rst_no_early_toggle", {23'h0, carry_en}, 24'h0);
    cyc(1);
    chk("post_rst_fresh_toggle", {23'h0, carry_en}, 24'h1);
    carry_set = 1'b0;
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
